jtag_axi_tap_mchain: RTL and testbench

Parametrised JTAG TAP controller with IEEE 1149.1 state machine, configurable-width instruction register, IDCODE, BYPASS and `NUM_CHAINS` user data-register chains. Each user chain has a parallel capture input, a registered parallel update output and per-chain capture/update strobes. It is the next generation of the fixed-instruction TAP front end and sits between the JTAG pins and the JTAG-to-AXI bridge logic.

---
 rtl/jtag_axi_tap_mchain.sv | 135 +++++++++++++
 tb/tb_jtag_axi_tap_mchain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_axi_tap_mchain.sv
// JTAG TAP controller with IDCODE, BYPASS and NUM_CHAINS user data-register chains.
// One shared user shift register feeds registered per-chain update outputs.
module jtag_axi_tap_mchain #(
  parameter logic [31:0] IDCODE_VAL = 32'hBADC0FFE,
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned NUM_CHAINS = 3,
  parameter int unsigned DR_WIDTH   = 32,
  parameter int unsigned USER_BASE  = 4
) (
  input  logic                             tck,
  input  logic                             trst,
  input  logic                             tms,
  input  logic                             tdi,
  output logic                             tdo,
  output logic                             tdo_en,
  output logic [3:0]                       tap_state_o,
  output logic [IR_WIDTH-1:0]              ir_o,
  input  logic [NUM_CHAINS*DR_WIDTH-1:0]   capture_data_i,
  output logic [NUM_CHAINS*DR_WIDTH-1:0]   update_data_o,
  output logic [NUM_CHAINS-1:0]            capture_o,
  output logic [NUM_CHAINS-1:0]            update_o
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC, SEL_DR  = 4'h7, CAP_DR = 4'h6,
    SH_DR   = 4'h2, EX1_DR  = 4'h1, PAUSE_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR  = 4'h5, SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR  = 4'hA,
    EX1_IR  = 4'h9, PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state, next_state;

  logic [IR_WIDTH-1:0]   ir_sr;
  logic [31:0]           id_sr;
  logic                  bp_sr;
  logic [DR_WIDTH-1:0]   user_sr;
  logic                  sel_idcode;
  logic [NUM_CHAINS-1:0] sel_user;
  logic [DR_WIDTH-1:0]   cap_sel;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TLR;
    else      state <= next_state;
  end

  // Standard 1149.1 state graph
  always_comb begin
    next_state = state;
    unique case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state = tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state = tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Opcode decode; anything not IDCODE or a user chain falls through to BYPASS
  always_comb begin
    sel_idcode = (ir_o == IR_WIDTH'(1));
    sel_user   = '0;
    cap_sel    = '0;
    for (int unsigned k = 0; k < NUM_CHAINS; k++) begin
      sel_user[k] = (ir_o == IR_WIDTH'(USER_BASE + k));
      if (sel_user[k]) cap_sel = capture_data_i[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr         <= '0;
      ir_o          <= IR_WIDTH'(1);
      id_sr         <= '0;
      bp_sr         <= 1'b0;
      user_sr       <= '0;
      update_data_o <= '0;
      capture_o     <= '0;
      update_o      <= '0;
    end else begin
      capture_o <= '0;
      update_o  <= '0;
      case (state)
        CAP_IR: ir_sr <= IR_WIDTH'(1);
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir_o  <= ir_sr;
        CAP_DR: begin
          if (sel_idcode) id_sr <= IDCODE_VAL;
          else if (|sel_user) begin
            user_sr   <= cap_sel;
            capture_o <= sel_user;
          end else bp_sr <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode) id_sr <= {tdi, id_sr[31:1]};
          else if (|sel_user) user_sr <= DR_WIDTH'({tdi, user_sr} >> 1);
          else bp_sr <= tdi;
        end
        UPD_DR: begin
          for (int unsigned k = 0; k < NUM_CHAINS; k++)
            if (sel_user[k]) update_data_o[k*DR_WIDTH +: DR_WIDTH] <= user_sr;
          update_o <= sel_user;
        end
        default: ;
      endcase
      // IDCODE is the active instruction whenever the TAP sits in Test-Logic-Reset
      if (next_state == TLR) ir_o <= IR_WIDTH'(1);
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR) tdo = ir_sr[0];
    else if (state == SH_DR) begin
      if (sel_idcode)     tdo = id_sr[0];
      else if (|sel_user) tdo = user_sr[0];
      else                tdo = bp_sr;
    end
  end

  assign tdo_en      = (state == SH_IR) || (state == SH_DR);
  assign tap_state_o = state;

endmodule

// File: tb/tb_jtag_axi_tap_mchain.sv
// Directed bench for jtag_axi_tap_mchain: reset, FSM walk, IR/BYPASS, user chains, pause, mid-shift reset.
module tb_jtag_axi_tap_mchain;

  localparam int unsigned IR_WIDTH   = 4;
  localparam int unsigned NUM_CHAINS = 3;
  localparam int unsigned DR_WIDTH   = 32;

  logic                           tck = 1'b0;
  logic                           trst = 1'b1;
  logic                           tms = 1'b1;
  logic                           tdi = 1'b0;
  logic                           tdo;
  logic                           tdo_en;
  logic [3:0]                     tap_state_o;
  logic [IR_WIDTH-1:0]            ir_o;
  logic [NUM_CHAINS*DR_WIDTH-1:0] capture_data_i = '0;
  logic [NUM_CHAINS*DR_WIDTH-1:0] update_data_o;
  logic [NUM_CHAINS-1:0]          capture_o;
  logic [NUM_CHAINS-1:0]          update_o;

  int checks = 0;
  int errors = 0;

  jtag_axi_tap_mchain #(
    .IDCODE_VAL(32'hBADC0FFE), .IR_WIDTH(IR_WIDTH), .NUM_CHAINS(NUM_CHAINS),
    .DR_WIDTH(DR_WIDTH), .USER_BASE(4)
  ) dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .tap_state_o(tap_state_o), .ir_o(ir_o), .capture_data_i(capture_data_i),
    .update_data_o(update_data_o), .capture_o(capture_o), .update_o(update_o)
  );

  always #5 tck = ~tck;

  // Drive one TCK cycle from a falling edge; o is tdo as seen before the rising edge
  task automatic tick(input logic t, input logic d, output logic o);
    tms = t;
    tdi = d;
    #1 o = tdo;
    @(posedge tck);
    @(negedge tck);
  endtask

  // RTI -> full IR or DR scan of n bits -> Update -> RTI
  task automatic scan(input logic is_ir, input int n, input logic [63:0] din,
                      output logic [63:0] dout, output logic [2:0] cap0, output logic [2:0] cap1);
    logic o;
    dout = '0;
    cap0 = '0;
    cap1 = '0;
    tick(1'b1, 1'b0, o);
    if (is_ir) tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      if (i == 0) cap0 = capture_o;
      if (i == 1) cap1 = capture_o;
      tick(i == n - 1, din[i], o);
      dout[i] = o;
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask

  task automatic test_reset;
    logic o;
    logic [63:0] d;
    logic [2:0] c0, c1;
    trst = 1'b1;
    repeat (2) @(negedge tck);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp F", tap_state_o); end
    checks++; if (ir_o !== 4'h1) begin errors++; $display("FAIL reset_ir got %h exp 1", ir_o); end
    checks++; if (update_data_o !== '0 || capture_o !== '0 || update_o !== '0)
      begin errors++; $display("FAIL reset_outputs got data=%h cap=%b upd=%b exp 0", update_data_o, capture_o, update_o); end
    checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b/%b exp 0/0", tdo, tdo_en); end
    trst = 1'b0;
    tick(1'b0, 1'b0, o);
    scan(1'b0, 32, 64'h0, d, c0, c1);
    checks++; if (d[31:0] !== 32'hBADC0FFE) begin errors++; $display("FAIL idcode_read got %h exp badc0ffe", d[31:0]); end
  endtask

  task automatic test_fsm_walk;
    logic o;
    logic       seq [17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp [17] = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'h7,
                             4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD, 4'hC};
    trst = 1'b1;
    @(negedge tck);
    trst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick(seq[i], 1'b0, o);
      checks++; if (tap_state_o !== exp[i]) begin errors++; $display("FAIL fsm_walk step %0d got %h exp %h", i, tap_state_o, exp[i]); end
      if (exp[i] == 4'h2 || exp[i] == 4'hA) begin
        checks++; if (tdo_en !== 1'b1) begin errors++; $display("FAIL tdo_en_shift step %0d got %b exp 1", i, tdo_en); end
      end
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    checks++; if (tap_state_o !== 4'h2) begin errors++; $display("FAIL reach_shdr got %h exp 2", tap_state_o); end
    repeat (5) tick(1'b1, 1'b0, o);
    checks++; if (tap_state_o !== 4'hF || ir_o !== 4'h1) begin errors++; $display("FAIL five_ones_tlr got state=%h ir=%h exp F/1", tap_state_o, ir_o); end
    tick(1'b0, 1'b0, o);
  endtask

  task automatic test_ir_bypass;
    logic [63:0] d;
    logic [2:0] c0, c1;
    scan(1'b1, 4, 64'hF, d, c0, c1);
    checks++; if (d[3:0] !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b exp 0001", d[3:0]); end
    checks++; if (ir_o !== 4'hF) begin errors++; $display("FAIL ir_update got %h exp f", ir_o); end
    scan(1'b0, 8, 64'hA5, d, c0, c1);
    checks++; if (d[7:0] !== 8'h4A) begin errors++; $display("FAIL bypass_delay got %h exp 4a", d[7:0]); end
    checks++; if (update_o !== 3'b000 || update_data_o !== '0) begin errors++; $display("FAIL bypass_no_update got %b/%h exp 0", update_o, update_data_o); end
  endtask

  task automatic test_user_chain;
    logic o;
    logic [63:0] d;
    logic [2:0] c0, c1;
    capture_data_i = {32'hCAFEF00D, 32'h0, 32'h0};
    scan(1'b1, 4, 64'h5, d, c0, c1);
    scan(1'b0, 32, 64'hDEADBEEF, d, c0, c1);
    checks++; if (c0 !== 3'b010 || c1 !== 3'b000) begin errors++; $display("FAIL cap_strobe1 got %b,%b exp 010,000", c0, c1); end
    checks++; if (update_o !== 3'b010) begin errors++; $display("FAIL upd_strobe got %b exp 010", update_o); end
    checks++; if (update_data_o !== 96'h00000000_DEADBEEF_00000000) begin errors++; $display("FAIL upd_data1 got %h exp deadbeef in slice 1", update_data_o); end
    tick(1'b0, 1'b0, o);
    checks++; if (update_o !== 3'b000) begin errors++; $display("FAIL upd_strobe_len got %b exp 000", update_o); end
    capture_data_i[63:32] = 32'h12345678;
    scan(1'b0, 32, 64'h0BADF00D, d, c0, c1);
    checks++; if (d[31:0] !== 32'h12345678) begin errors++; $display("FAIL chain1_read got %h exp 12345678", d[31:0]); end
    checks++; if (update_data_o !== 96'h00000000_0BADF00D_00000000) begin errors++; $display("FAIL upd_data2 got %h", update_data_o); end
    scan(1'b1, 4, 64'h6, d, c0, c1);
    checks++; if (update_data_o !== 96'h00000000_0BADF00D_00000000) begin errors++; $display("FAIL ir_keeps_data got %h", update_data_o); end
    scan(1'b0, 32, 64'h0, d, c0, c1);
    checks++; if (d[31:0] !== 32'hCAFEF00D || c0 !== 3'b100) begin errors++; $display("FAIL chain2_read got %h cap=%b exp cafef00d cap=100", d[31:0], c0); end
    checks++; if (update_o !== 3'b100) begin errors++; $display("FAIL chain2_upd got %b exp 100", update_o); end
    scan(1'b1, 4, 64'h3, d, c0, c1);
    checks++; if (ir_o !== 4'h3) begin errors++; $display("FAIL unused_ir got %h exp 3", ir_o); end
    scan(1'b0, 8, 64'h3C, d, c0, c1);
    checks++; if (d[7:0] !== 8'h78 || update_o !== 3'b000 || c0 !== 3'b000) begin errors++; $display("FAIL unused_bypass got %h upd=%b cap=%b exp 78/000/000", d[7:0], update_o, c0); end
    checks++; if (update_data_o !== 96'h00000000_0BADF00D_00000000) begin errors++; $display("FAIL unused_keeps_data got %h", update_data_o); end
  endtask

  task automatic test_pause_hold;
    logic o;
    logic [63:0] d;
    logic [2:0] c0, c1;
    logic [31:0] v = 32'h13579BDF;
    scan(1'b1, 4, 64'h4, d, c0, c1);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 16; i++) tick(i == 15, v[i], o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, o);
    checks++; if (tap_state_o !== 4'h3 || tdo_en !== 1'b0) begin errors++; $display("FAIL pause_state got %h/%b exp 3/0", tap_state_o, tdo_en); end
    tick(1'b1, 1'b1, o);
    tick(1'b0, 1'b1, o);
    for (int i = 16; i < 32; i++) tick(i == 31, v[i], o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    checks++; if (update_data_o[31:0] !== 32'h13579BDF || update_o !== 3'b001) begin errors++; $display("FAIL pause_hold got %h upd=%b exp 13579bdf/001", update_data_o[31:0], update_o); end
  endtask

  task automatic test_reset_mid_shift;
    logic o;
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, o);
    #2 trst = 1'b1;
    #1;
    checks++; if (tap_state_o !== 4'hF || ir_o !== 4'h1) begin errors++; $display("FAIL mid_reset_state got %h/%h exp F/1", tap_state_o, ir_o); end
    checks++; if (update_data_o !== '0 || update_o !== '0 || tdo_en !== 1'b0) begin errors++; $display("FAIL mid_reset_data got %h upd=%b en=%b exp 0", update_data_o, update_o, tdo_en); end
    @(negedge tck);
    trst = 1'b0;
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    checks++; if (update_o !== '0 || tap_state_o !== 4'hC) begin errors++; $display("FAIL post_reset got upd=%b state=%h exp 0/C", update_o, tap_state_o); end
  endtask

  initial begin
    @(negedge tck);
    test_reset;
    test_fsm_walk;
    test_ir_bypass;
    test_user_chain;
    test_pause_hold;
    test_reset_mid_shift;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
